nes_joypad_serializer: RTL

//  Multi-port NES controller serializer: latches per-port parallel button vectors on joypad strobe,

---
 rtl/nes_joypad_serializer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/nes_joypad_serializer.sv
// nes_joypad_serializer
//   Multi-port NES controller serializer. On joypad strobe each port latches its
//   (synchronised, autofire-masked) button vector. Each falling edge of that port's
//   joypad clock then shifts one bit out. Once the report is exhausted, the fill bit
//   is returned until the next strobe.
//
// Ports
//   clk            system clock (NES clock domain)
//   reset_n        asynchronous active-low reset
//   i_btn          buttons, active high, port p = [p*C_bits +: C_bits], bit0 = A (async source)
//   i_autofire_en  per port: bit 2p = autofire on A, bit 2p+1 = autofire on B
//   i_strobe       joypad strobe, level sensitive, clk domain
//   i_joy_clock    per-port joypad read clock, clk domain
//   o_data         registered serial button data per port, active high
//   o_autofire_ph  current autofire phase (1 = button passes)
module nes_joypad_serializer #(
   parameter int   C_ports       = 2,
   parameter int   C_bits        = 8,
   parameter logic C_fill        = 1'b1,
   parameter int   C_clk_hz      = 21428571,
   parameter int   C_autofire_hz = 10
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [C_ports*C_bits-1:0]   i_btn,
   input  logic [C_ports*2-1:0]        i_autofire_en,
   input  logic                        i_strobe,
   input  logic [C_ports-1:0]          i_joy_clock,
   output logic [C_ports-1:0]          o_data,
   output logic                        o_autofire_ph
);

   // Divider is guarded so a disabled autofire never divides by zero and an
   // over-fast rate still yields a legal one-cycle half period.
   localparam int AF_DIV      = (C_autofire_hz > 0) ? 2 * C_autofire_hz : 1;
   localparam int AF_HALF_RAW = C_clk_hz / AF_DIV;
   localparam int AF_HALF     = (AF_HALF_RAW > 0) ? AF_HALF_RAW : 1;
   localparam int AF_W        = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
   localparam int CNT_W       = $clog2(C_bits + 1);

   logic [C_ports*C_bits-1:0] btn_s_p0;
   logic [C_ports*C_bits-1:0] btn_s_p1;
   logic                      af_phase;

   // Stage p0/p1: two-flop synchroniser for the asynchronous button inputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_s_p0 <= '0;
         btn_s_p1 <= '0;
      end else begin
         btn_s_p0 <= i_btn;
         btn_s_p1 <= btn_s_p0;
      end
   end

   if (C_autofire_hz > 0) begin : g_af
      logic [AF_W-1:0] af_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
         end else if (af_cnt == AF_W'(AF_HALF - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
         end else begin
            af_cnt   <= af_cnt + 1'b1;
         end
      end
   end else begin : g_no_af
      assign af_phase = 1'b1;
   end

   assign o_autofire_ph = af_phase;

   for (genvar p = 0; p < C_ports; p++) begin : g_port
      logic [C_bits-1:0] af_mask;
      logic [C_bits-1:0] eff;
      logic [C_bits-1:0] sr;
      logic [C_bits:0]   shifted;
      logic [CNT_W-1:0]  cnt;
      logic              prev_clk;
      logic              data_q;

      // Only A (bit0) and B (bit1) are subject to autofire; the rest pass through.
      if (C_bits == 1) begin : g_mask1
         assign af_mask = af_phase | ~i_autofire_en[2*p];
      end else begin : g_mask2
         assign af_mask[1:0] = {af_phase | ~i_autofire_en[2*p+1],
                                af_phase | ~i_autofire_en[2*p]};
         if (C_bits > 2) begin : g_mask_rest
            assign af_mask[C_bits-1:2] = '1;
         end
      end

      assign eff     = btn_s_p1[p*C_bits +: C_bits] & af_mask;
      assign shifted = {C_fill, sr};

      // Stage p2: latch/shift, then register the visible bit one cycle later
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sr       <= '0;
            cnt      <= '0;
            prev_clk <= 1'b0;
            data_q   <= 1'b0;
         end else begin
            prev_clk <= i_joy_clock[p];
            // Strobe reloads continuously and beats a coincident falling edge.
            if (i_strobe) begin
               sr  <= eff;
               cnt <= '0;
            end else if (prev_clk && !i_joy_clock[p]) begin
               sr <= shifted[C_bits:1];
               if (cnt != CNT_W'(C_bits)) begin
                  cnt <= cnt + 1'b1;
               end
            end
            data_q <= (cnt == CNT_W'(C_bits)) ? C_fill : sr[0];
         end
      end

      assign o_data[p] = data_q;
   end

endmodule
